// File: rtl/clint_responder.sv
// Machine-level core-local interruptor (msip, mtime, mtimecmp) on the native mem_valid/mem_ready bus.
// Latency: mem_ready one cycle after the first cycle a hit is seen; IRQ3/IRQ7 registered (1-cycle lag).
// Backpressure: none; every in-window request is answered in fixed time, out-of-window requests are ignored.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   mem_valid/mem_ready         request / one-cycle response strobe
//   mem_wstrb/mem_addr/mem_wdata byte enables (0 = read), byte address, write data
//   mem_rdata/access_fault      read data and error flag, both 0 whenever mem_ready is 0
//   IRQ3 / IRQ7                 machine software / machine timer interrupt
module clint_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        access_fault,
    output logic        IRQ3,
    output logic        IRQ7
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    localparam logic [15:0] LP_OFF_MSIP   = 16'h0000;
    localparam logic [15:0] LP_OFF_CMP_LO = 16'h4000;
    localparam logic [15:0] LP_OFF_CMP_HI = 16'h4004;
    localparam logic [15:0] LP_OFF_MT_LO  = 16'hBFF8;
    localparam logic [15:0] LP_OFF_MT_HI  = 16'hBFFC;
    localparam logic [15:0] LP_PRESC_TOP  = 16'(TICK_DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_ready;

    logic        r_msip;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [15:0] r_presc;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        r_irq3;
    logic        r_irq7;

    logic        w_hit;
    logic        w_acc;
    logic [15:0] w_off;
    logic        w_sel_msip;
    logic        w_sel_cmp_lo;
    logic        w_sel_cmp_hi;
    logic        w_sel_mt_lo;
    logic        w_sel_mt_hi;
    logic        w_fault;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic [31:0] w_rd_val;
    logic [63:0] w_mtime_nxt;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Address decode; only evaluated as an access while the FSM is idle.
    assign w_hit        = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
    assign w_acc        = w_hit && (r_state == S_IDLE);
    assign w_off        = mem_addr[15:0];
    assign w_sel_msip   = (w_off == LP_OFF_MSIP);
    assign w_sel_cmp_lo = (w_off == LP_OFF_CMP_LO);
    assign w_sel_cmp_hi = (w_off == LP_OFF_CMP_HI);
    assign w_sel_mt_lo  = (w_off == LP_OFF_MT_LO);
    assign w_sel_mt_hi  = (w_off == LP_OFF_MT_HI);
    assign w_fault      = (mem_addr[1:0] != 2'b00) ||
                          !(w_sel_msip || w_sel_cmp_lo || w_sel_cmp_hi || w_sel_mt_lo || w_sel_mt_hi);
    assign w_wr         = w_acc && !w_fault && (mem_wstrb != 4'b0000);
    assign w_rd         = w_acc && !w_fault && (mem_wstrb == 4'b0000);
    assign w_tick       = (r_presc == LP_PRESC_TOP);

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state and response strobe
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Read mux; mtime reads see the value before this edge's increment.
    always_comb begin
        w_rd_val = 32'h0;
        if (w_sel_msip) begin
            w_rd_val = {31'h0, r_msip};
        end else if (w_sel_cmp_lo) begin
            w_rd_val = r_mtimecmp[31:0];
        end else if (w_sel_cmp_hi) begin
            w_rd_val = r_mtimecmp[63:32];
        end else if (w_sel_mt_lo) begin
            w_rd_val = r_mtime[31:0];
        end else if (w_sel_mt_hi) begin
            w_rd_val = r_mtime[63:32];
        end
    end

    // A bus write to either mtime half wins over the tick: the increment is
    // dropped for that edge and unwritten bytes keep the pre-increment value.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_sel_mt_lo) begin
            w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], mem_wdata, mem_wstrb);
        end else if (w_wr && w_sel_mt_hi) begin
            w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], mem_wdata, mem_wstrb);
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_msip     <= 1'b0;
            r_mtime    <= 64'h0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_presc    <= 16'h0;
            r_rdata    <= 32'h0;
            r_fault    <= 1'b0;
            r_irq3     <= 1'b0;
            r_irq7     <= 1'b0;
        end else begin
            // Prescaler runs regardless of bus writes to mtime.
            r_presc <= w_tick ? 16'h0 : (r_presc + 16'h1);
            r_mtime <= w_mtime_nxt;

            if (w_wr && w_sel_msip && mem_wstrb[0]) begin
                r_msip <= mem_wdata[0];
            end
            if (w_wr && w_sel_cmp_lo) begin
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], mem_wdata, mem_wstrb);
            end
            if (w_wr && w_sel_cmp_hi) begin
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], mem_wdata, mem_wstrb);
            end

            // Response data lives only for the ACK cycle; cleared on every other edge.
            r_rdata <= w_rd ? w_rd_val : 32'h0;
            r_fault <= w_acc && w_fault;

            r_irq3 <= r_msip;
            r_irq7 <= (r_mtime >= r_mtimecmp);
        end
    end

    assign mem_ready    = w_ready;
    assign mem_rdata    = r_rdata;
    assign access_fault = r_fault;
    assign IRQ3         = r_irq3;
    assign IRQ7         = r_irq7;

endmodule

// File: tb/tb_clint_responder.sv
// Bench for clint_responder: two instances (TICK_DIV 1 and 4) share one bus; a
// reference model tracks msip/mtimecmp and computes mtime arithmetically from
// the number of clock edges since reset and the last mtime write.
module tb_clint_responder;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [1:0]        vld;
    logic [3:0]        wstrb;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        rdy;
    logic [1:0]        flt;
    logic [1:0]        irq3;
    logic [1:0]        irq7;
    logic [1:0][31:0]  rdata;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    clint_responder #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .mem_valid(vld[0]), .mem_ready(rdy[0]),
        .mem_wstrb(wstrb), .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata[0]),
        .access_fault(flt[0]), .IRQ3(irq3[0]), .IRQ7(irq7[0])
    );

    clint_responder #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .mem_valid(vld[1]), .mem_ready(rdy[1]),
        .mem_wstrb(wstrb), .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata[1]),
        .access_fault(flt[1]), .IRQ3(irq3[1]), .IRQ7(irq7[1])
    );

    // Edges since reset release.
    longint ecnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) ecnt <= 0;
        else         ecnt <= ecnt + 1;
    end

    // Reference model
    logic        m_msip [2];
    logic [63:0] m_cmp  [2];
    logic [63:0] m_base [2];
    longint      m_w    [2];

    function automatic longint div(input int i);
        return (i == 0) ? 64'd1 : 64'd4;
    endfunction

    // mtime after n edges: value written at edge m_w plus ticks strictly after it.
    function automatic logic [63:0] mt_at(input int i, input longint n);
        return m_base[i] + 64'(n / div(i)) - 64'(m_w[i] / div(i));
    endfunction

    function automatic logic [31:0] bytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_msip[i] = 1'b0;
            m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_base[i] = 64'h0;
            m_w[i]    = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction on instance i, starting and ending at a negedge.
    task automatic bus(input int i, input logic [31:0] a, input logic [3:0] st,
                       input logic [31:0] wd, input int ow_wait, output logic [31:0] rd);
        logic [63:0] pre;
        logic [31:0] exp_rd;
        logic        old_msip;
        logic        is_fault;
        logic [15:0] off;
        longint      x;
        addr   = a;
        wstrb  = st;
        wdata  = wd;
        vld[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x  = ecnt;
        rd = rdata[i];
        if (a[31:16] != BASE[31:16]) begin
            chk("oow_no_ready", rdy[i], 1'b0);
            for (int k = 0; k < ow_wait; k++) begin
                @(negedge clk);
                chk("oow_no_ready_hold", rdy[i], 1'b0);
            end
            vld[i] = 1'b0;
            @(negedge clk);
            return;
        end
        off      = a[15:0];
        is_fault = (a[1:0] != 2'b00) ||
                   !(off inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
        pre      = mt_at(i, x - 1);
        old_msip = m_msip[i];
        chk("ready", rdy[i], 1'b1);
        chk("fault", flt[i], is_fault);
        if (is_fault) begin
            chk("fault_rdata", rd, 32'h0);
        end else if (st == 4'b0000) begin
            case (off)
                16'h0000: exp_rd = {31'h0, m_msip[i]};
                16'h4000: exp_rd = m_cmp[i][31:0];
                16'h4004: exp_rd = m_cmp[i][63:32];
                16'hBFF8: exp_rd = pre[31:0];
                default:  exp_rd = pre[63:32];
            endcase
            chk("rdata", rd, exp_rd);
        end else begin
            case (off)
                16'h0000: if (st[0]) m_msip[i] = wd[0];
                16'h4000: m_cmp[i][31:0]  = bytes(m_cmp[i][31:0], wd, st);
                16'h4004: m_cmp[i][63:32] = bytes(m_cmp[i][63:32], wd, st);
                16'hBFF8: begin m_base[i] = {pre[63:32], bytes(pre[31:0], wd, st)}; m_w[i] = x; end
                default:  begin m_base[i] = {bytes(pre[63:32], wd, st), pre[31:0]}; m_w[i] = x; end
            endcase
        end
        chk("irq3_ack", irq3[i], old_msip);
        vld[i] = 1'b0;
        @(negedge clk);
        chk("ready_drop", rdy[i], 1'b0);
        chk("idle_rdata", rdata[i], 32'h0);
        chk("idle_fault", flt[i], 1'b0);
        chk("irq3", irq3[i], m_msip[i]);
        chk("irq7", irq7[i], mt_at(i, ecnt - 1) >= m_cmp[i]);
    endtask

    task automatic idle_check(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_irq7", irq7[i], mt_at(i, ecnt - 1) >= m_cmp[i]);
            chk("idle_ready", rdy[i], 1'b0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  st;
        logic        seen;
        int          inst;

        vld = 2'b00; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", rdy[i], 1'b0);
            chk("rst_rdata", rdata[i], 32'h0);
            chk("rst_fault", flt[i], 1'b0);
            chk("rst_irq3", irq3[i], 1'b0);
            chk("rst_irq7", irq7[i], 1'b0);
        end
        resetn = 1'b1;
        @(negedge clk);

        // 1: mtimecmp hi after reset
        bus(0, BASE + 32'h4004, 4'h0, 32'h0, 0, rd);
        chk("t1_cmp_hi", rd, 32'hFFFF_FFFF);

        // 2: msip write / readback / clear
        bus(0, BASE, 4'b0001, 32'h1, 0, rd);
        chk("t2_irq3_set", irq3[0], 1'b1);
        bus(0, BASE, 4'h0, 32'h0, 0, rd);
        chk("t2_msip_rd", rd, 32'h1);
        bus(0, BASE, 4'b0001, 32'h0, 0, rd);
        chk("t2_irq3_clr", irq3[0], 1'b0);

        // 3: TICK_DIV=4 timer interrupt
        bus(1, BASE + 32'h4000, 4'hF, 32'd8, 0, rd);
        bus(1, BASE + 32'h4004, 4'hF, 32'd0, 0, rd);
        bus(1, BASE + 32'hBFFC, 4'hF, 32'd0, 0, rd);
        bus(1, BASE + 32'hBFF8, 4'hF, 32'd0, 0, rd);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk("t3_irq7_track", irq7[1], mt_at(1, ecnt - 1) >= m_cmp[1]);
            if (irq7[1] === 1'b1) seen = 1'b1;
        end
        chk("t3_irq7_rose", seen, 1'b1);
        bus(1, BASE + 32'h4004, 4'hF, 32'd1, 0, rd);
        chk("t3_irq7_fell", irq7[1], 1'b0);

        // 4: carry into mtime hi, then partial write on an increment edge
        bus(0, BASE + 32'hBFFC, 4'hF, 32'h0, 0, rd);
        bus(0, BASE + 32'hBFF8, 4'hF, 32'hFFFF_FFFF, 0, rd);
        bus(0, BASE + 32'hBFFC, 4'h0, 32'h0, 0, rd);
        chk("t4_carry_hi", rd, 32'h1);
        bus(0, BASE + 32'hBFF8, 4'b0011, 32'h0000_1234, 0, rd);
        bus(0, BASE + 32'hBFF8, 4'h0, 32'h0, 0, rd);
        chk("t4_lo_low_half", rd[15:0] >= 16'h1234, 1'b1);

        // 5: faults and out-of-window
        bus(0, BASE + 32'h0008, 4'h0, 32'h0, 0, rd);
        bus(0, BASE + 32'h4002, 4'hF, 32'hDEAD_BEEF, 0, rd);
        bus(0, BASE + 32'h4000, 4'h0, 32'h0, 0, rd);
        chk("t5_cmp_lo_kept", rd, 32'hFFFF_FFFF);
        bus(0, BASE + 32'h4004, 4'h0, 32'h0, 0, rd);
        bus(0, BASE + 32'h1_0000, 4'hF, 32'h1, 20, rd);

        // 6: reset during ACK, then back-to-back requests
        bus(0, BASE, 4'b0001, 32'h1, 0, rd);
        addr = BASE + 32'h4004; wstrb = 4'h0; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_ack_before_rst", rdy[0], 1'b1);
        resetn = 1'b0;
        #1;
        chk("t6_ready_async", rdy[0], 1'b0);
        chk("t6_rdata_async", rdata[0], 32'h0);
        chk("t6_irq3_async", irq3[0], 1'b0);
        vld[0] = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus(0, BASE, 4'h0, 32'h0, 0, rd);
        chk("t6_msip_rst", rd, 32'h0);
        bus(0, BASE + 32'h4000, 4'h0, 32'h0, 0, rd);
        bus(0, BASE + 32'hBFF8, 4'h0, 32'h0, 0, rd);
        bus(1, BASE + 32'hBFF8, 4'h0, 32'h0, 0, rd);
        addr = BASE; wstrb = 4'h0; vld[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t6_b2b_first", rdy[0], 1'b1);
        @(posedge clk); @(negedge clk);
        chk("t6_b2b_gap", rdy[0], 1'b0);
        @(posedge clk); @(negedge clk);
        chk("t6_b2b_second", rdy[0], 1'b1);
        vld[0] = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            inst = int'($urandom_range(0, 1));
            case ($urandom_range(0, 11))
                0, 1:    a = BASE;
                2:       a = BASE + 32'h4000;
                3:       a = BASE + 32'h4004;
                4, 5:    a = BASE + 32'hBFF8;
                6:       a = BASE + 32'hBFFC;
                7:       a = BASE + 32'h0008;
                8:       a = BASE + 32'h4002;
                9:       a = BASE + 32'h1000;
                10:      a = BASE + 32'hBFF9;
                default: a = ($urandom_range(0, 1) == 0) ? BASE + 32'h1_0000 : 32'h0300_BFF8;
            endcase
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus(inst, a, st, $urandom, 3, rd);
            idle_check(inst, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
